// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bus bundle between the two requesters (CPU load/store path "C" and the
// read-only fetch engine "V"), the shared single-port memory, and the
// arbiter.
//
// Modports:
//   master : the environment side. It drives requests and memory read data,
//            and observes grants, read returns and the memory strobe.
//   slave  : the arbiter side (mem_port_arbiter).
//
// Handshake: a requester holds req/addr/we/wdata stable until it samples
// gnt=1 at a rising edge. It may then drop req or keep it high for a
// back-to-back access. A read returns with a one-cycle rvalid pulse in the
// cycle after the grant. rdata holds its value between returns.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 16
);
   // CPU port
   logic                 c_req;
   logic                 c_we;
   logic [ADDR_BITS-1:0] c_addr;
   logic [WIDTH-1:0]     c_wdata;
   logic                 c_gnt;
   logic                 c_rvalid;
   logic [WIDTH-1:0]     c_rdata;
   // fetch-engine port
   logic                 v_req;
   logic [ADDR_BITS-1:0] v_addr;
   logic                 v_gnt;
   logic                 v_rvalid;
   logic [WIDTH-1:0]     v_rdata;
   // memory side
   logic                 mem_en;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [WIDTH-1:0]     mem_wdata;
   logic [WIDTH-1:0]     mem_rdata;

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      output v_req, v_addr,
      input  v_gnt, v_rvalid, v_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata,
      input  v_req, v_addr,
      output v_gnt, v_rvalid, v_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous single-port data memory between the CPU load/store
// path (port C) and a read-only fetch engine (port V). At most one access is
// granted per cycle. The grant is combinational from the request lines and
// registered state, and the winner's request is driven to memory in the
// same cycle. Read data is routed back to the requesting port in the next
// cycle with a one-cycle rvalid pulse.
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : mem_port_arbiter_if.slave
//           c_req/c_we/c_addr/c_wdata -> c_gnt, c_rvalid, c_rdata
//           v_req/v_addr               -> v_gnt, v_rvalid, v_rdata
//           mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//
// Arbitration:
//   default build          : V wins contention up to MAX_BURST times in a
//                            row, then C wins once (burst_cnt bound).
//   MEM_ARB_ROUND_ROBIN_EN : whichever port was not granted last wins
//                            contention; last_grant resets to C.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 16,
   parameter int MAX_BURST = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   // Which port owns the read data arriving from memory this cycle.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_C    = 2'd1,
      TAG_V    = 2'd2
   } tag_t;

   tag_t             rd_tag, rd_tag_nxt;
   logic [WIDTH-1:0] c_hold, v_hold;
   logic             grant_c, grant_v;
   logic             run;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   typedef enum logic {
      LAST_C = 1'b0,
      LAST_V = 1'b1
   } last_t;
   last_t last_grant, last_grant_nxt;
`else
   localparam logic [3:0] MAX_B = 4'(MAX_BURST);
   logic [3:0] burst_cnt, burst_cnt_nxt;
`endif

   // While reset is asserted nothing is granted and every output reads 0,
   // even before the reset edge clears the registers.
   assign run = reset;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_tag     <= TAG_NONE;
         c_hold     <= '0;
         v_hold     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant <= LAST_C;
`else
         burst_cnt  <= '0;
`endif
      end else begin
         rd_tag <= rd_tag_nxt;
         if (rd_tag == TAG_C) c_hold <= bus.mem_rdata;
         if (rd_tag == TAG_V) v_hold <= bus.mem_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant <= last_grant_nxt;
`else
         burst_cnt  <= burst_cnt_nxt;
`endif
      end
   end

   // ---------------- grant decision / next state ----------------
   always_comb begin
      grant_c    = 1'b0;
      grant_v    = 1'b0;
      rd_tag_nxt = TAG_NONE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_nxt = last_grant;
`else
      burst_cnt_nxt  = burst_cnt;
`endif
      if (run) begin
         if (bus.c_req && bus.v_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_grant == LAST_C) grant_v = 1'b1;
            else                      grant_c = 1'b1;
`else
            if (burst_cnt < MAX_B) begin
               grant_v       = 1'b1;
               burst_cnt_nxt = burst_cnt + 4'd1;
            end else begin
               grant_c       = 1'b1;
               burst_cnt_nxt = '0;
            end
`endif
         end else if (bus.c_req) begin
            grant_c = 1'b1;
`ifndef MEM_ARB_ROUND_ROBIN_EN
            burst_cnt_nxt = '0;
`endif
         end else if (bus.v_req) begin
            grant_v = 1'b1;
            // C is not waiting, so this V grant does not count toward a burst.
`ifndef MEM_ARB_ROUND_ROBIN_EN
            burst_cnt_nxt = '0;
`endif
         end
      end

`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (grant_c) last_grant_nxt = LAST_C;
      if (grant_v) last_grant_nxt = LAST_V;
`endif

      // The tag follows each grant, so alternating grants still return to
      // the right port.
      if (grant_c && !bus.c_we) rd_tag_nxt = TAG_C;
      else if (grant_v)         rd_tag_nxt = TAG_V;
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.c_gnt     = grant_c;
      bus.v_gnt     = grant_v;
      bus.mem_en    = grant_c | grant_v;
      bus.mem_we    = grant_c & bus.c_we;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (grant_c) begin
         bus.mem_addr = bus.c_addr;
         if (bus.c_we) bus.mem_wdata = bus.c_wdata;
      end else if (grant_v) begin
         bus.mem_addr = bus.v_addr;
      end

      // Read data is passed straight through in the return cycle, and the
      // hold register supplies it afterwards.
      bus.c_rvalid = run && (rd_tag == TAG_C);
      bus.v_rvalid = run && (rd_tag == TAG_V);
      bus.c_rdata  = '0;
      bus.v_rdata  = '0;
      if (run) begin
         bus.c_rdata = bus.c_rvalid ? bus.mem_rdata : c_hold;
         bus.v_rdata = bus.v_rvalid ? bus.mem_rdata : v_hold;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int W = 16;
   localparam int A = 16;
   localparam int RW = 3 + A + W;   // grant record: {c_gnt, v_gnt, mem_we, mem_addr, wdata}

   logic clk;
   logic reset;

   mem_port_arbiter_if #(.WIDTH(W), .ADDR_BITS(A)) bus ();

   mem_port_arbiter #(.WIDTH(W), .ADDR_BITS(A), .MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   logic [W-1:0] ram [0:65535];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= ram[bus.mem_addr];
      end
   end

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [RW-1:0] exp_gnt_q[$];
   logic [W-1:0]  exp_c_q[$];
   logic [W-1:0]  exp_v_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] rec(input logic c, input logic v, input logic we,
                                         input logic [A-1:0] addr, input logic [W-1:0] wd);
      return {c, v, we, addr, wd};
   endfunction

   // Monitor: pops an expectation whenever the DUT presents a grant or a return.
   always @(negedge clk) begin
      if (bus.c_gnt || bus.v_gnt) begin
         if (exp_gnt_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got c=%0b v=%0b addr=%0h expected no grant",
                     bus.c_gnt, bus.v_gnt, bus.mem_addr);
         end else begin
            check("grant", 64'(rec(bus.c_gnt, bus.v_gnt, bus.mem_we, bus.mem_addr,
                                   bus.mem_we ? bus.mem_wdata : '0)),
                  64'(exp_gnt_q.pop_front()));
         end
      end
      if (bus.c_rvalid) begin
         if (exp_c_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL c_rvalid_unexpected: got data %0h expected no return", bus.c_rdata);
         end else check("c_rdata", 64'(bus.c_rdata), 64'(exp_c_q.pop_front()));
      end
      if (bus.v_rvalid) begin
         if (exp_v_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL v_rvalid_unexpected: got data %0h expected no return", bus.v_rdata);
         end else check("v_rdata", 64'(bus.v_rdata), 64'(exp_v_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   // Each task is entered just after a rising edge and returns just after the
   // grant edge, so a following call issues a back-to-back request.
   task automatic c_access(input logic we, input logic [A-1:0] addr,
                           input logic [W-1:0] wd, input logic last);
      int n;
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
      n = 0;
      @(negedge clk);
      while (!bus.c_gnt && n < 50) begin @(negedge clk); n++; end
      if (!bus.c_gnt) begin
         checks++; errors++;
         $display("FAIL c_gnt_timeout: got no grant expected grant for addr %0h", addr);
      end
      @(posedge clk); #1;
      if (last) begin bus.c_req = 1'b0; bus.c_we = 1'b0; end
   endtask

   task automatic v_access(input logic [A-1:0] addr, input logic last);
      int n;
      bus.v_req = 1'b1; bus.v_addr = addr;
      n = 0;
      @(negedge clk);
      while (!bus.v_gnt && n < 50) begin @(negedge clk); n++; end
      if (!bus.v_gnt) begin
         checks++; errors++;
         $display("FAIL v_gnt_timeout: got no grant expected grant for addr %0h", addr);
      end
      @(posedge clk); #1;
      if (last) bus.v_req = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 64'({bus.c_gnt, bus.c_rvalid, bus.c_rdata, bus.v_gnt, bus.v_rvalid,
                       bus.v_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
            64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
      ram[16'h0010] = 16'hBEEF;
      ram[16'h0030] = 16'hC030;
      ram[16'h0031] = 16'hC031;
      ram[16'h0040] = 16'h00AA;
      ram[16'h0041] = 16'h0055;
      for (int i = 0; i < 8; i++) ram[16'h0100 + i] = 16'h5100 + 16'(i);

      bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
      bus.v_req = 0; bus.v_addr = '0;
      bus.mem_rdata = '0;
      reset = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_outputs");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset_idle");
      @(posedge clk); #1;

      // single C read
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0010, 16'h0));
      exp_c_q.push_back(16'hBEEF);
      c_access(0, 16'h0010, 16'h0, 1);
      @(negedge clk);
      check("c_read_rvalid", 64'(bus.c_rvalid), 64'd1);
      check("c_read_no_v", 64'(bus.v_rvalid), 64'd0);
      @(posedge clk); #1;

      // C store then load of the same address
      exp_gnt_q.push_back(rec(1, 0, 1, 16'h0020, 16'h1234));
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0020, 16'h0));
      exp_c_q.push_back(16'h1234);
      c_access(1, 16'h0020, 16'h1234, 0);
      c_access(0, 16'h0020, 16'h0, 1);
      @(posedge clk); #1;
      check("c_rdata_hold", 64'(bus.c_rdata), 64'h1234);

      // V read, then idle hold
      exp_gnt_q.push_back(rec(0, 1, 0, 16'h0040, 16'h0));
      exp_v_q.push_back(16'h00AA);
      v_access(16'h0040, 1);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_mem_en", 64'(bus.mem_en), 64'd0);
         check("idle_gnt", 64'({bus.c_gnt, bus.v_gnt}), 64'd0);
         check("idle_rvalid", 64'({bus.c_rvalid, bus.v_rvalid}), 64'd0);
         check("idle_v_rdata", 64'(bus.v_rdata), 64'h00AA);
      end
      @(posedge clk); #1;

      // reset while a V read is in flight
      exp_gnt_q.push_back(rec(0, 1, 0, 16'h0041, 16'h0));
      v_access(16'h0041, 1);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_no_v_rvalid", 64'(bus.v_rvalid), 64'd0);
      check_all_zero("midreset_outputs");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("after_reset_v_rdata", 64'(bus.v_rdata), 64'h0);
      @(posedge clk); #1;

      // contention: both requesting from a clean reset
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_gnt_q.push_back(rec(0, 1, 0, 16'h0100, 16'h0));
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0030, 16'h0));
      exp_gnt_q.push_back(rec(0, 1, 0, 16'h0101, 16'h0));
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0031, 16'h0));
      for (int i = 2; i < 8; i++) exp_gnt_q.push_back(rec(0, 1, 0, 16'h0100 + 16'(i), 16'h0));
`else
      for (int i = 0; i < 4; i++) exp_gnt_q.push_back(rec(0, 1, 0, 16'h0100 + 16'(i), 16'h0));
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0030, 16'h0));
      for (int i = 4; i < 8; i++) exp_gnt_q.push_back(rec(0, 1, 0, 16'h0100 + 16'(i), 16'h0));
      exp_gnt_q.push_back(rec(1, 0, 0, 16'h0031, 16'h0));
`endif
      for (int i = 0; i < 8; i++) exp_v_q.push_back(16'h5100 + 16'(i));
      exp_c_q.push_back(16'hC030);
      exp_c_q.push_back(16'hC031);
      fork
         begin
            c_access(0, 16'h0030, 16'h0, 0);
            c_access(0, 16'h0031, 16'h0, 1);
         end
         begin
            for (int i = 0; i < 8; i++) v_access(16'h0100 + 16'(i), (i == 7));
         end
      join

      // drain and final report
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("gnt_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
      check("c_queue_empty", 64'(exp_c_q.size()), 64'd0);
      check("v_queue_empty", 64'(exp_v_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
